// File: rtl/fifo_read_packer.sv
// Read-side packer for the NPU data FIFO: pops PACK_COUNT words of DATA_WIDTH bits and
// presents them as one wide beat to the PE/MAC array over a valid/ready handshake.
module fifo_read_packer #(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned PACK_COUNT = 4,
  localparam int unsigned CNT_W      = $clog2(PACK_COUNT) + 1
) (
  input  logic                             clk,
  input  logic                             reset_b,
  input  logic                             pack_en,
  input  logic                             pack_flush,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  output logic                             fifo_rd_enb,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] out_data,
  output logic [CNT_W-1:0]                 word_cnt
);

  localparam int unsigned BEAT_W = DATA_WIDTH * PACK_COUNT;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              capture_pend_q, capture_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [BEAT_W-1:0] out_data_q, out_data_d;
  logic              rd_en_c;

  // Pop request; gated by reset so nothing is requested while the block is held in reset.
  assign rd_en_c = reset_b && (state_q == ST_FILL) && pack_en && !fifo_empty && !pack_flush
                   && (issued_q < CNT_W'(PACK_COUNT));

  always_comb begin
    state_d        = state_q;
    issued_d       = issued_q;
    word_cnt_d     = word_cnt_q;
    capture_pend_d = rd_en_c;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;

    if (rd_en_c) begin
      issued_d = issued_q + CNT_W'(1);
    end

    if (pack_flush) begin
      // Flush drops the partial beat and any in-flight read; lanes keep their old contents.
      state_d        = ST_FILL;
      issued_d       = '0;
      word_cnt_d     = '0;
      capture_pend_d = 1'b0;
      out_valid_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (capture_pend_q) begin
            for (int i = 0; i < int'(PACK_COUNT); i++) begin
              if (word_cnt_q == CNT_W'(i)) begin
                out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
              end
            end
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (word_cnt_q == CNT_W'(PACK_COUNT - 1)) begin
              state_d     = ST_HOLD;
              out_valid_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_valid_q && out_ready) begin
            state_d     = ST_FILL;
            issued_d    = '0;
            word_cnt_d  = '0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= ST_FILL;
      issued_q       <= '0;
      word_cnt_q     <= '0;
      capture_pend_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      issued_q       <= issued_d;
      word_cnt_q     <= word_cnt_d;
      capture_pend_q <= capture_pend_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
    end
  end

  assign fifo_rd_enb = rd_en_c;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign word_cnt    = word_cnt_q;

  // Structural invariants between issue and capture counters.
  a_cnt_order: assert property (@(posedge clk) disable iff (!reset_b)
    word_cnt_q <= issued_q);
  a_cnt_gap: assert property (@(posedge clk) disable iff (!reset_b)
    issued_q <= word_cnt_q + CNT_W'(1));
  a_issued_max: assert property (@(posedge clk) disable iff (!reset_b)
    issued_q <= CNT_W'(PACK_COUNT));
  a_no_rd_in_hold: assert property (@(posedge clk) disable iff (!reset_b)
    (state_q == ST_HOLD) |-> !fifo_rd_enb);

endmodule
